// File: rtl/nibble_sub_pkg.sv
// Shared constants for the nibble-serial add/subtract unit.
// Holds FSM state encodings and default operand geometry.
package nibble_sub_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SLICE_DEF = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE-bit adder with generate/propagate lookahead.
// Exposes carry into the MSB so the caller can derive signed overflow.
module add_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flat OR of every generate term propagated up to it.
    always_comb begin
        logic t;
        c    = '0;
        t    = 1'b0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            t = cin;
            for (int k = 0; k <= i; k++) t = t & p[k];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int k = j + 1; k <= i; k++) t = t & p[k];
                c[i+1] = c[i+1] | t;
            end
        end
    end

    assign sum   = p ^ c[SLICE-1:0];
    assign cout  = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/nibble_sub_16.sv
// Slice-serial add/subtract: one SLICE-bit chunk per clock.
// Flags are registered on the final slice and held until consumed.
module nibble_sub_16
    import nibble_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cf,
    output logic             ovf,
    output logic             zero
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_nxt;
    logic             op_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] s_sum;
    logic             s_cout;
    logic             s_msb;
    logic             last;

    add_slice #(.SLICE(SLICE)) u_slice (
        .a     (a_q[cnt*SLICE +: SLICE]),
        .b     (b_q[cnt*SLICE +: SLICE]),
        .cin   (carry),
        .sum   (s_sum),
        .cout  (s_cout),
        .c_msb (s_msb)
    );

    assign last      = (cnt == CW'(NS - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        res_nxt = res;
        res_nxt[cnt*SLICE +: SLICE] = s_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            cf    <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= op ? ~b : b;
                        op_q  <= op;
                        carry <= op;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    res   <= res_nxt;
                    carry <= s_cout;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        // Subtract reports borrow, i.e. inverted carry-out.
                        cf    <= op_q ^ s_cout;
                        ovf   <= s_msb ^ s_cout;
                        zero  <= (res_nxt == '0);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_sub_16.sv
// Directed bench for nibble_sub_16 against a word-level arithmetic model.
// A negedge monitor compares handshake and results every cycle.
module tb_nibble_sub_16;

    localparam int W  = 16;
    localparam int NS = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  res;
    logic          cf;
    logic          ovf;
    logic          zero;

    int total = 0;
    int bad   = 0;

    nibble_sub_16 #(.WIDTH(W), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .cf        (cf),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Word-level model: 0 idle, 1 computing, 2 holding result.
    int           m_state = 0;
    int           m_left  = 0;
    logic [W-1:0] m_res;
    logic         m_cf;
    logic         m_ovf;
    logic         m_zero;
    bit           armed   = 0;

    always @(posedge clk) begin
        logic [W:0] s;
        if (rst) begin
            m_state = 0;
            armed   = 1;
        end else if (m_state == 0) begin
            if (in_valid) begin
                if (op) s = {1'b0, a} - {1'b0, b};
                else    s = {1'b0, a} + {1'b0, b};
                m_res  = s[W-1:0];
                m_cf   = s[W];
                m_zero = (m_res == 0);
                if (op) m_ovf = (a[W-1] != b[W-1]) && (m_res[W-1] != a[W-1]);
                else    m_ovf = (a[W-1] == b[W-1]) && (m_res[W-1] != a[W-1]);
                m_left  = NS;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            m_left--;
            if (m_left == 0) m_state = 2;
        end else if (out_ready) begin
            m_state = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("mon_in_ready", in_ready, m_state == 0);
            chk("mon_out_valid", out_valid, m_state == 2);
            if (m_state == 2) begin
                chk("mon_res", res, m_res);
                chk("mon_cf", cf, m_cf);
                chk("mon_ovf", ovf, m_ovf);
                chk("mon_zero", zero, m_zero);
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run(input string tag, input logic o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ecf,
                       input logic eovf, input logic ez);
        int n;
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; op = ~o; a = ~x; b = y ^ 16'hA5A5;
        wait_done(n);
        chk({tag, "_latency"}, n, NS);
        chk({tag, "_res"}, res, er);
        chk({tag, "_cf"}, cf, ecf);
        chk({tag, "_ovf"}, ovf, eovf);
        chk({tag, "_zero"}, zero, ez);
        chk({tag, "_model_res"}, m_res, er);
        chk({tag, "_model_cf"}, m_cf, ecf);
        chk({tag, "_model_ovf"}, m_ovf, eovf);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_release"}, out_valid, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; op = 1'b0;
        a = '0; b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, 16'h0000);
        chk("rst_flags", {cf, ovf, zero}, 3'b000);

        run("sub0", 1'b1, 16'h6677, 16'h2233, 16'h4444, 0, 0, 0);
        run("sub1", 1'b1, 16'h1234, 16'h5678, 16'hBBBC, 1, 0, 0);
        run("sub2", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0);
        run("add0", 1'b0, 16'h8888, 16'h7777, 16'hFFFF, 0, 0, 0);
        run("add1", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1);
        run("add2", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0);
        run("sub3", 1'b1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);

        // Hold in DONE while new operands are offered.
        in_valid = 1'b1; op = 1'b0; a = 16'h0102; b = 16'h0304;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(n);
        chk("hold_latency", n, NS);
        in_valid = 1'b1; op = 1'b1; a = 16'hAAAA; b = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_res", res, 16'h0406);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_idle", in_ready, 1);
        chk("hold_idle_ov", out_valid, 0);
        @(posedge clk); #1;
        chk("hold_accept", in_ready, 0);
        in_valid = 1'b0;
        wait_done(n);
        chk("hold2_latency", n, NS);
        chk("hold2_res", res, 16'h9999);
        chk("hold2_cf", cf, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset on the second BUSY edge discards the operation.
        in_valid = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_res", res, 16'h0000);
        chk("mid_flags", {cf, ovf, zero}, 3'b000);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("mid_no_pulse", out_valid, 0);
        end

        run("post", 1'b0, 16'h1234, 16'h4321, 16'h5555, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
